// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the burst write arbiter.
package fifo_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
  localparam int BURST_LEN_DEF = 4;
endpackage

// File: rtl/rr_picker.sv
// Combinational winner select: round-robin from last_owner+1, or lowest index
// when FIFO_WR_ARB_FIXED_PRIO_EN is defined. Zero latency, no backpressure.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         last_owner,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [2:0]         winner_idx
);

  int idx;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    idx        = 0;
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
    // Scan high to low so the lowest set bit is the final assignment.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner_oh    = '0;
        winner_oh[i] = 1'b1;
        winner_idx   = 3'(i);
      end
    end
`else
    // Farthest candidate first; the nearest one after last_owner overrides.
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_owner) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (idx == i && req[i]) begin
          winner_oh    = '0;
          winner_oh[i] = 1'b1;
          winner_idx   = 3'(i);
        end
      end
    end
`endif
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Grants one requester a BURST_LEN-byte burst into a shared FIFO; build option FIFO_WR_ARB_FIXED_PRIO_EN.
// Grant one cycle after req; bytes pass combinationally; fifo_full or owner valid low stalls the burst.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   valid,
  input  logic [NUM_REQ*8-1:0] data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   ack,
  output logic [2:0]           owner,
  output logic                 fifo_en,
  output logic [7:0]           fifo_data_in,
  input  logic                 fifo_full
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           last_owner_q, last_owner_d;
  logic [2:0]           owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;

  logic [NUM_REQ-1:0]   win_oh;
  logic [2:0]           win_idx;
  logic                 own_vld;
  logic [7:0]           own_dat;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (req),
    .last_owner (last_owner_q),
    .winner_oh  (win_oh),
    .winner_idx (win_idx)
  );

  always_comb begin
    own_vld = 1'b0;
    own_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == 3'(i)) begin
        own_vld = valid[i];
        own_dat = data[i*8 +: 8];
      end
    end
  end

  assign fifo_en      = (state_q == BURST) && own_vld && !fifo_full;
  assign fifo_data_in = (state_q == BURST) ? own_dat : 8'h00;
  assign grant        = grant_q;
  assign owner        = owner_q;

  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i] = fifo_en && (owner_q == 3'(i));
    end
  end

  // The grant is held until a full word is written, whatever req/valid do.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    case (state_q)
      IDLE: begin
        if ((|req) && !fifo_full) begin
          state_d = BURST;
          owner_d = win_idx;
          grant_d = win_oh;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (fifo_en) begin
          if (cnt_q == CNT_LAST) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
            grant_d      = '0;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_owner_q <= 3'(NUM_REQ - 1);
      owner_q      <= '0;
      grant_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb (NUM_REQ=4, BURST_LEN=4) with hand-computed expectations.
module tb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, valid, grant, ack;
  logic [31:0] data;
  logic [2:0]  owner;
  logic        fifo_en, fifo_full;
  logic [7:0]  fifo_data_in;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] wq[$];
  logic [7:0] rq_byte [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  int exp_own [5];
  int exp_fix [2];

  always #5 clk = ~clk;

  fifo_wr_arb #(.NUM_REQ(4), .BURST_LEN(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .valid        (valid),
    .data         (data),
    .grant        (grant),
    .ack          (ack),
    .owner        (owner),
    .fifo_en      (fifo_en),
    .fifo_data_in (fifo_data_in),
    .fifo_full    (fifo_full)
  );

  // Model of the FIFO write port: every strobed byte is captured.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && fifo_en === 1'b1) wq.push_back(fifo_data_in);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; valid = '0; fifo_full = 1'b0; data = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] word0();
    return {wq[3], wq[2], wq[1], wq[0]};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
    exp_own = '{0, 0, 0, 0, 0};
    exp_fix = '{1, 1};
`else
    exp_own = '{0, 1, 2, 3, 0};
    exp_fix = '{1, 2};
`endif
    // Reset state
    rst_n = 1'b0; req = '0; valid = '0; fifo_full = 1'b0; data = '0;
    step();
    step();
    chk("rst_grant", grant, 0);
    chk("rst_fifo_en", fifo_en, 0);
    chk("rst_ack", ack, 0);
    chk("rst_data", fifo_data_in, 0);
    chk("rst_owner", owner, 0);
    rst_n = 1'b1;

    // Single burst from requester 0, bytes 1..4
    req = 4'b0001; valid = 4'b0001; data[7:0] = 8'd1;
    #1;
    chk("t1_idle_grant", grant, 0);
    chk("t1_idle_en", fifo_en, 0);
    step();
    req = 4'b0000;
    #1;
    chk("t1_grant", grant, 4'b0001);
    chk("t1_ack", ack, 4'b0001);
    for (int b = 1; b <= 4; b++) begin
      data[7:0] = 8'(b);
      #1;
      chk("t1_en", fifo_en, 1);
      chk("t1_byte", fifo_data_in, b);
      step();
    end
    chk("t1_end_grant", grant, 0);
    chk("t1_end_en", fifo_en, 0);
    chk("t1_word_cnt", wq.size(), 4);
    chk("t1_word", word0(), 32'h04030201);
    wq.delete();

    // All requesters busy: grant order and one idle cycle between bursts
    do_reset();
    req = 4'b1111; valid = 4'b1111;
    data = {rq_byte[3], rq_byte[2], rq_byte[1], rq_byte[0]};
    #1;
    for (int b = 0; b < 5; b++) begin
      chk("t2_gap_grant", grant, 0);
      step();
      chk("t2_grant", grant, 32'(1) << exp_own[b]);
      chk("t2_owner", owner, exp_own[b]);
      for (int k = 0; k < 4; k++) begin
        chk("t2_en", fifo_en, 1);
        chk("t2_byte", fifo_data_in, rq_byte[exp_own[b]]);
        step();
      end
    end
    req = '0;
    chk("t2_total", wq.size(), 20);
    wq.delete();

    // fifo_full stall after byte 2
    req = 4'b0100; valid = 4'b0100; data[23:16] = 8'h31;
    #1;
    step();
    req = '0;
    #1;
    chk("t3_grant", grant, 4'b0100);
    chk("t3_en1", fifo_en, 1);
    step();
    data[23:16] = 8'h32;
    #1;
    chk("t3_byte2", fifo_data_in, 8'h32);
    step();
    fifo_full = 1'b1; data[23:16] = 8'h33;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("t3_full_en", fifo_en, 0);
      chk("t3_full_ack", ack, 0);
      chk("t3_full_grant", grant, 4'b0100);
      step();
    end
    fifo_full = 1'b0;
    #1;
    chk("t3_byte3", fifo_data_in, 8'h33);
    chk("t3_ack3", ack, 4'b0100);
    step();
    data[23:16] = 8'h34;
    #1;
    chk("t3_byte4", fifo_data_in, 8'h34);
    step();
    chk("t3_end_grant", grant, 0);
    chk("t3_word_cnt", wq.size(), 4);
    chk("t3_word", word0(), 32'h34333231);
    wq.delete();

    // Owner valid gap while requester 1 waits
    req = 4'b1000; valid = 4'b1000; data[31:24] = 8'h51; data[15:8] = 8'hEE;
    #1;
    step();
    req = 4'b1010; valid = 4'b1010;
    #1;
    chk("t4_grant", grant, 4'b1000);
    chk("t4_byte1", fifo_data_in, 8'h51);
    step();
    valid = 4'b0010;
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("t4_gap_en", fifo_en, 0);
      chk("t4_gap_ack", ack, 0);
      chk("t4_gap_grant", grant, 4'b1000);
      step();
    end
    valid = 4'b1010;
    for (int b = 2; b <= 4; b++) begin
      data[31:24] = 8'h50 + 8'(b);
      #1;
      chk("t4_ack", ack, 4'b1000);
      chk("t4_byte", fifo_data_in, 8'h50 + 8'(b));
      step();
    end
    chk("t4_end_grant", grant, 0);
    step();
    chk("t4_next_grant", grant, 4'b0010);
    chk("t4_word_cnt", wq.size(), 4);
    chk("t4_word", word0(), 32'h54535251);
    wq.delete();

    // Reset mid-burst after two bytes of requester 1
    req = '0;
    #1;
    chk("t5_byte", fifo_data_in, 8'hEE);
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_en", fifo_en, 0);
    chk("t5_rst_owner", owner, 0);
    rst_n = 1'b1; req = 4'b1111; valid = 4'b1111;
    #1;
    step();
    chk("t5_after_grant", grant, 4'b0001);

    // req=0110 held: fixed priority keeps requester 1, round-robin alternates
    do_reset();
    req = 4'b0110; valid = 4'b0110;
    #1;
    for (int b = 0; b < 2; b++) begin
      step();
      chk("t6_grant", grant, 32'(1) << exp_fix[b]);
      for (int k = 0; k < 4; k++) step();
      chk("t6_idle", grant, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte-stream requesters (2..8).
REQ-002 Parameter BURST_LEN, default 4, bytes per grant, equal to bytes per FIFO output word.
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  NUM_REQ  requester i wants one BURST_LEN-byte burst.
REQ-006 valid  input  NUM_REQ  requester i presents a byte this cycle.
REQ-007 data  input  NUM_REQ*8  byte of requester i in bits [8i+7:8i].
REQ-008 grant  output  NUM_REQ  one-hot; current burst owner.
REQ-009 ack  output  NUM_REQ  one-hot; owner's byte accepted this cycle.
REQ-010 owner  output  3  index of current or last owner.
REQ-011 fifo_en  output  1  write strobe to FIFO en.
REQ-012 fifo_data_in  output  8  byte to FIFO data_in.
REQ-013 fifo_full  input  1  FIFO full flag.

Function
REQ-014 FSM states IDLE and BURST shall be the only states.
REQ-015 In IDLE, grant shall be 0 and fifo_en 0.
REQ-016 In IDLE with any req bit set and fifo_full=0, the arbiter shall pick a winner and enter BURST on the next edge, with grant[winner]=1 and byte counter=0.
REQ-017 Round-robin: search shall start at (last_owner+1) mod NUM_REQ and wrap.
REQ-018 In BURST, fifo_en shall be valid[owner] & ~fifo_full, combinationally.
REQ-019 fifo_data_in shall equal data[owner] whenever in BURST; it shall be 0 in IDLE.
REQ-020 ack[owner] shall equal fifo_en; all other ack bits 0.
REQ-021 Each fifo_en cycle shall increment the byte counter.
REQ-022 The accepted byte at counter=BURST_LEN-1 shall end the burst: IDLE next cycle, last_owner<=owner, grant cleared.
REQ-023 Minimum grant-to-grant spacing shall be one IDLE cycle.
REQ-024 Owner deasserting req or valid mid-burst shall not release grant; the burst stalls until BURST_LEN bytes are written (word alignment).
REQ-025 fifo_full=1 shall stall the burst with no byte lost, counter held, and ack=0.
REQ-026 fifo_full=1 in IDLE shall block new grants.
REQ-027 Non-owner valid/data shall be ignored.

Reset
REQ-028 On rst_n=0 at an edge: state=IDLE, counter=0, last_owner=NUM_REQ-1, owner=0, grant=0; ack=0, fifo_en=0, fifo_data_in=0 combinationally.
REQ-029 Reset mid-burst shall abandon the partial word; the FIFO shares rst_n and discards it too.

Configuration
REQ-030 Macro FIFO_WR_ARB_FIXED_PRIO_EN: when defined, winner shall be the lowest-index req bit, ignoring last_owner; when undefined, round-robin per REQ-017.

Structure
REQ-031 Shared package fifo_arb_pkg shall hold the state enum (IDLE, BURST) and the BURST_LEN default constant.
REQ-032 Sub-module rr_picker (combinational: req, last_owner -> one-hot winner and index) shall implement REQ-017 and REQ-030.

Verification
REQ-033 Reset, then req=4'b0001, valid[0]=1, data0 = 1,2,3,4 -> grant=0001 one cycle later; fifo_en high 4 cycles with bytes 1,2,3,4; IDLE after; FIFO word 0x04030201.
REQ-034 req=4'b1111 held, all valid=1 -> grants in order 0,1,2,3,0, each burst 4 bytes, one IDLE cycle between bursts.
REQ-035 fifo_full=1 for 3 cycles after byte 2 of a burst -> fifo_en=0 and ack=0 for those 3 cycles; bytes 3,4 follow with no duplicates.
REQ-036 valid[owner]=0 for 2 cycles mid-burst while req[1]=1 -> grant stays on owner; no write from requester 1 until burst ends.
REQ-037 rst_n=0 after byte 2 -> next edge IDLE, grant=0; next grant goes to requester 0.
REQ-038 With FIFO_WR_ARB_FIXED_PRIO_EN defined, req=4'b0110 held -> requester 1 wins every burst.
